// File: rtl/frame_length_delimiter_pkg.sv
// Shared definitions for the frame-length delimiter and its extractor twin:
// the two-state encoding and the timestamp footer byte count.
package frame_length_delimiter_pkg;

    typedef enum logic [0:0] {
        STATE_IDLE   = 1'b0,
        STATE_STREAM = 1'b1
    } state_t;

    // Footer bytes appended after each frame body; zero when the footer is off.
    function automatic int ts_bytes(input bit enable_footer, input int timestamp_width);
        return enable_footer ? (timestamp_width / 8) : 0;
    endfunction

endpackage

// File: rtl/frame_length_delimiter_if.sv
// AXI4-Stream style channel used for the length side channel and the
// frame data input/output of the frame-length delimiter.
interface frame_length_delimiter_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/frame_length_delimiter.sv
// Frame-length delimiter: takes one length per frame from a side channel and
// forwards exactly length + footer bytes, regenerating tlast from the count.
// Optional build macro FRAME_LENGTH_CHECK_EN adds a sticky length_error flag
// raised when the input tlast disagrees with the regenerated one.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   STATE_IDLE   | waiting for a length word; data channel stalled
//   STATE_STREAM | passing bytes through, remaining_q beats left after this
module frame_length_delimiter
    import frame_length_delimiter_pkg::*;
#(
    parameter int DATA_WIDTH              = 8,
    parameter int FRAME_LENGTH_WIDTH      = 16,
    parameter int ENABLE_TIMESTAMP_FOOTER = 1,
    parameter int TIMESTAMP_WIDTH         = 72
) (
    input  logic                      clk,
    input  logic                      rstn,
    frame_length_delimiter_if.slave   s_axis_frame_length,
    frame_length_delimiter_if.slave   s_axis,
    frame_length_delimiter_if.master  m_axis,
    output logic                      length_error
);

    localparam int TS_BYTES = ts_bytes(ENABLE_TIMESTAMP_FOOTER != 0, TIMESTAMP_WIDTH);
    // One extra bit so length + footer never wraps.
    localparam int CNT_W    = FRAME_LENGTH_WIDTH + 1;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   remaining_q;
    logic [CNT_W-1:0]   remaining_d;
    logic [CNT_W-1:0]   total;
    logic               len_hs;
    logic               data_hs;
    logic               last_beat;

    assign total     = {1'b0, s_axis_frame_length.tdata} + CNT_W'(TS_BYTES);
    assign len_hs    = s_axis_frame_length.tvalid && s_axis_frame_length.tready;
    assign data_hs   = s_axis.tvalid && s_axis.tready;
    assign last_beat = (remaining_q == '0);

    // Handshake and pass-through outputs; everything is held quiet while
    // rstn is low so a mid-frame reset stops traffic in the same cycle.
    always_comb begin
        s_axis_frame_length.tready = 1'b0;
        s_axis.tready              = 1'b0;
        m_axis.tvalid              = 1'b0;
        m_axis.tlast               = 1'b0;
        m_axis.tdata               = s_axis.tdata;
        if (rstn) begin
            case (state_q)
                STATE_IDLE: begin
                    s_axis_frame_length.tready = 1'b1;
                end
                STATE_STREAM: begin
                    s_axis.tready = m_axis.tready;
                    m_axis.tvalid = s_axis.tvalid;
                    m_axis.tlast  = last_beat;
                end
                default: begin
                    s_axis_frame_length.tready = 1'b0;
                end
            endcase
        end
    end

    // Next state and beat counter.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            STATE_IDLE: begin
                // A zero total consumes the length and stays idle.
                if (len_hs && (total != '0)) begin
                    remaining_d = total - CNT_W'(1);
                    state_d     = STATE_STREAM;
                end
            end
            STATE_STREAM: begin
                if (data_hs) begin
                    if (last_beat) begin
                        state_d = STATE_IDLE;
                    end else begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = STATE_IDLE;
                remaining_d = '0;
            end
        endcase
    end

    // State and counter registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= STATE_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

`ifdef FRAME_LENGTH_CHECK_EN
    logic length_error_q;
    logic length_error_d;

    // Sticky flag: any beat whose input tlast differs from the regenerated one.
    always_comb begin
        length_error_d = length_error_q;
        if ((state_q == STATE_STREAM) && data_hs && (s_axis.tlast != last_beat)) begin
            length_error_d = 1'b1;
        end
    end

    // Error flag register; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            length_error_q <= 1'b0;
        end else begin
            length_error_q <= length_error_d;
        end
    end

    assign length_error = length_error_q;
`else
    assign length_error = 1'b0;
`endif

endmodule

// File: tb/tb_frame_length_delimiter.sv
// Bench for frame_length_delimiter: queue-based reference of the expected
// byte stream and frame boundaries, random valid/ready, directed scenarios.
`timescale 1ns/1ps
module tb_frame_length_delimiter;

    localparam int DW  = 8;
    localparam int LW  = 16;
    localparam int TSB = 9;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    frame_length_delimiter_if #(.WIDTH(LW)) len_if ();
    frame_length_delimiter_if #(.WIDTH(DW)) s_if ();
    frame_length_delimiter_if #(.WIDTH(DW)) m_if ();
    logic length_error;

    frame_length_delimiter #(
        .DATA_WIDTH(DW), .FRAME_LENGTH_WIDTH(LW),
        .ENABLE_TIMESTAMP_FOOTER(1), .TIMESTAMP_WIDTH(72)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_frame_length(len_if), .s_axis(s_if), .m_axis(m_if),
        .length_error(length_error)
    );

    // Second instance with the footer disabled, for the zero-length case.
    frame_length_delimiter_if #(.WIDTH(LW)) l2_if ();
    frame_length_delimiter_if #(.WIDTH(DW)) s2_if ();
    frame_length_delimiter_if #(.WIDTH(DW)) m2_if ();
    logic length_error2;

    frame_length_delimiter #(
        .DATA_WIDTH(DW), .FRAME_LENGTH_WIDTH(LW),
        .ENABLE_TIMESTAMP_FOOTER(0), .TIMESTAMP_WIDTH(72)
    ) dut_nf (
        .clk(clk), .rstn(rstn),
        .s_axis_frame_length(l2_if), .s_axis(s2_if), .m_axis(m2_if),
        .length_error(length_error2)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    int unsigned len_q[$];
    logic [7:0]  dat_q[$];
    logic        dlast_q[$];
    beat_t       exp_q[$];

    int  len_pct = 100;
    int  val_pct = 100;
    int  rdy_pct = 100;
    bit  flush   = 1'b0;

    int  checks = 0;
    int  errors = 0;

    bit  in_frame  = 1'b0;
    bit  err_exp   = 1'b0;
    int  cur_beats = 0;
    int  frame_beats_q[$];
    int  last_cyc_q[$];
    int  acc_cyc_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Queue one frame: body of len bytes plus footer. bad_beat (1-based) moves
    // the input tlast onto that beat; 0 puts it on the true last byte.
    task automatic add_frame(input int len, input int bad_beat);
        int total;
        total = len + TSB;
        len_q.push_back(len);
        for (int i = 0; i < total; i++) begin
            beat_t b;
            b.data = 8'($urandom_range(255));
            b.last = (i == total - 1);
            dat_q.push_back(b.data);
            dlast_q.push_back((bad_beat > 0) ? (i == bad_beat - 1) : b.last);
            exp_q.push_back(b);
        end
    endtask

    task automatic clear_obs();
        frame_beats_q.delete();
        last_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rstn  = 1'b0;
        flush = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rstn  = 1'b1;
        flush = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((len_q.size() != 0 || dat_q.size() != 0 || exp_q.size() != 0 || in_frame) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
            do_reset();
        end
        repeat (3) @(posedge clk);
    endtask

    // Source/sink driver: presents queued lengths and bytes with random gaps,
    // holding valid data stable until it is taken.
    initial begin : driver
        bit lh;
        bit dh;
        len_if.tvalid = 1'b0; len_if.tdata = '0; len_if.tlast = 1'b0;
        s_if.tvalid   = 1'b0; s_if.tdata   = '0; s_if.tlast   = 1'b0;
        m_if.tready   = 1'b0;
        forever begin
            @(negedge clk);
            lh = len_if.tvalid && len_if.tready;
            dh = s_if.tvalid && s_if.tready;
            @(posedge clk); #1;
            if (flush) begin
                len_q.delete();
                dat_q.delete();
                dlast_q.delete();
                len_if.tvalid = 1'b0;
                s_if.tvalid   = 1'b0;
            end else begin
                if (lh) void'(len_q.pop_front());
                if (dh) begin
                    void'(dat_q.pop_front());
                    void'(dlast_q.pop_front());
                end
                if (lh || !len_if.tvalid) begin
                    if (len_q.size() > 0 && $urandom_range(99) < len_pct) begin
                        len_if.tvalid = 1'b1;
                        len_if.tdata  = LW'(len_q[0]);
                    end else begin
                        len_if.tvalid = 1'b0;
                    end
                end
                if (dh || !s_if.tvalid) begin
                    if (dat_q.size() > 0 && $urandom_range(99) < val_pct) begin
                        s_if.tvalid = 1'b1;
                        s_if.tdata  = dat_q[0];
                        s_if.tlast  = dlast_q[0];
                    end else begin
                        s_if.tvalid = 1'b0;
                    end
                end
            end
            m_if.tready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Compare process: every cycle, away from the clock edge.
    initial begin : compare
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk1("rst_len_tready", len_if.tready, 1'b0);
                chk1("rst_s_tready", s_if.tready, 1'b0);
                chk1("rst_m_tvalid", m_if.tvalid, 1'b0);
                chk1("rst_m_tlast", m_if.tlast, 1'b0);
                chk1("rst_length_error", length_error, 1'b0);
                in_frame  = 1'b0;
                err_exp   = 1'b0;
                cur_beats = 0;
            end else begin
                chk1("len_tready", len_if.tready, !in_frame);
                chk1("s_tready", s_if.tready, in_frame && m_if.tready);
                chk1("m_tvalid", m_if.tvalid, in_frame && s_if.tvalid);
                chk1("length_error", length_error, err_exp);
                if (!in_frame) chk1("m_tlast_idle", m_if.tlast, 1'b0);
                if (m_if.tvalid) chk8("m_tdata_passthru", m_if.tdata, s_if.tdata);
                if (len_if.tvalid && len_if.tready) begin
                    in_frame = 1'b1;
                    acc_cyc_q.push_back(cycle);
                end else if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        chk1("unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk8("beat_data", m_if.tdata, e.data);
                        chk1("beat_tlast", m_if.tlast, e.last);
`ifdef FRAME_LENGTH_CHECK_EN
                        if (s_if.tlast != e.last) err_exp = 1'b1;
`endif
                        cur_beats++;
                        if (e.last) begin
                            in_frame = 1'b0;
                            frame_beats_q.push_back(cur_beats);
                            last_cyc_q.push_back(cycle);
                            cur_beats = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int nframes;
        logic exp_err5;

        l2_if.tvalid = 1'b0; l2_if.tdata = '0; l2_if.tlast = 1'b0;
        s2_if.tvalid = 1'b0; s2_if.tdata = '0; s2_if.tlast = 1'b0;
        m2_if.tready = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Footer disabled: length 0 is consumed with no output, then length 3.
        @(posedge clk); #1;
        l2_if.tdata = 16'd0; l2_if.tvalid = 1'b1;
        s2_if.tvalid = 1'b1; s2_if.tdata = 8'h5A; m2_if.tready = 1'b1;
        @(negedge clk);
        chk1("nf_len0_accept", l2_if.tready, 1'b1);
        chk1("nf_len0_no_beat", m2_if.tvalid, 1'b0);
        @(posedge clk); #1;
        l2_if.tvalid = 1'b0;
        @(negedge clk);
        chk1("nf_len0_ready_next", l2_if.tready, 1'b1);
        chk1("nf_len0_still_no_beat", m2_if.tvalid, 1'b0);
        @(posedge clk); #1;
        l2_if.tdata = 16'd3; l2_if.tvalid = 1'b1;
        @(negedge clk);
        chk1("nf_len3_accept", l2_if.tready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            l2_if.tvalid = 1'b0;
            s2_if.tdata  = 8'(8'hA0 + i);
            s2_if.tlast  = (i == 2);
            @(negedge clk);
            chk1("nf_beat_valid", m2_if.tvalid, 1'b1);
            chk8("nf_beat_data", m2_if.tdata, 8'(8'hA0 + i));
            chk1("nf_beat_tlast", m2_if.tlast, (i == 2));
            chk1("nf_len_tready_busy", l2_if.tready, 1'b0);
        end
        @(posedge clk); #1;
        s2_if.tlast = 1'b0;
        @(negedge clk);
        chk1("nf_back_idle", l2_if.tready, 1'b1);
        chk1("nf_idle_no_beat", m2_if.tvalid, 1'b0);
        chk1("nf_length_error", length_error2, 1'b0);
        @(posedge clk); #1;
        s2_if.tvalid = 1'b0; m2_if.tready = 1'b0;

        // Length 64, continuous flow: 73 beats, accepted 73 cycles before tlast.
        len_pct = 100; val_pct = 100; rdy_pct = 100;
        clear_obs();
        add_frame(64, 0);
        wait_done("t1", 2000);
        chk("t1_frames", frame_beats_q.size(), 1);
        if (frame_beats_q.size() >= 1) begin
            chk("t1_beats", frame_beats_q[0], 73);
            chk("t1_accept_to_last", last_cyc_q[0] - acc_cyc_q[0], 73);
        end

        // Length 64 under random backpressure.
        rdy_pct = 50;
        clear_obs();
        add_frame(64, 0);
        wait_done("t2", 4000);
        chk("t2_frames", frame_beats_q.size(), 1);
        if (frame_beats_q.size() >= 1) chk("t2_beats", frame_beats_q[0], 73);

        // Back-to-back 60 and 61: one bubble cycle between frames.
        rdy_pct = 100;
        clear_obs();
        add_frame(60, 0);
        add_frame(61, 0);
        wait_done("t4", 4000);
        chk("t4_frames", frame_beats_q.size(), 2);
        if (frame_beats_q.size() >= 2 && acc_cyc_q.size() >= 2) begin
            chk("t4_beats0", frame_beats_q[0], 69);
            chk("t4_beats1", frame_beats_q[1], 70);
            chk("t4_accept_after_last", acc_cyc_q[1] - last_cyc_q[0], 1);
            chk("t4_last_spacing", last_cyc_q[1] - last_cyc_q[0], 71);
        end

        // Input tlast early on beat 70: framing unchanged, error flag sticky.
`ifdef FRAME_LENGTH_CHECK_EN
        exp_err5 = 1'b1;
`else
        exp_err5 = 1'b0;
`endif
        clear_obs();
        add_frame(64, 70);
        wait_done("t5", 2000);
        chk("t5_frames", frame_beats_q.size(), 1);
        if (frame_beats_q.size() >= 1) chk("t5_beats", frame_beats_q[0], 73);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk1("t5_error_sticky", length_error, exp_err5);
        do_reset();
        @(negedge clk);
        chk1("t5_error_cleared", length_error, 1'b0);

        // Reset after 10 beats of a 64-byte frame, then a fresh 46-byte frame.
        clear_obs();
        add_frame(64, 0);
        n = 0;
        while (cur_beats < 10 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("t6_reached_10_beats", cur_beats, 10);
        do_reset();
        @(negedge clk);
        chk1("t6_len_tready_after_reset", len_if.tready, 1'b1);
        chk1("t6_m_tvalid_after_reset", m_if.tvalid, 1'b0);
        clear_obs();
        add_frame(46, 0);
        wait_done("t6", 2000);
        chk("t6_frames", frame_beats_q.size(), 1);
        if (frame_beats_q.size() >= 1) chk("t6_beats", frame_beats_q[0], 55);

        // Random lengths and handshake densities.
        clear_obs();
        nframes = 0;
        for (int batch = 0; batch < 3; batch++) begin
            len_pct = 50 + $urandom_range(50);
            val_pct = 50 + $urandom_range(50);
            rdy_pct = 50 + $urandom_range(50);
            for (int f = 0; f < 8; f++) begin
                add_frame($urandom_range(80), 0);
                nframes++;
            end
            wait_done("rand", 20000);
        end
        chk("rand_frames", frame_beats_q.size(), nframes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
